// File: rtl/motor_pwm_pkg.sv
// rtl/motor_pwm_pkg.sv - shared types and direction decode for the motor PWM driver
package motor_pwm_pkg;

  localparam int DUTY_W = 5;

  typedef enum logic [1:0] {
    COAST = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    ST_COAST = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2
  } chan_state_t;

  // a==b (including the illegal 1/1) coasts, so both bridge inputs can never be driven high
  function automatic dir_t decode_dir(input logic a, input logic b);
    if (a && !b)
      return FWD;
    else if (!a && b)
      return REV;
    else
      return COAST;
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// rtl/motor_pwm_channel.sv - one wheel: command FSM, duty slew limiter and registered bridge outputs
import motor_pwm_pkg::*;

module motor_pwm_channel #(
  parameter int RAMP_STEP    = 2,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_boundary,
  input  logic [DUTY_W-1:0] i_pwm_cnt,
  input  logic              i_a,
  input  logic              i_b,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_in1,
  output logic              o_in2,
  output logic              o_dead
);

  localparam logic [DUTY_W-1:0] STEP   = DUTY_W'(RAMP_STEP);
  localparam logic [3:0]        DEAD_N = 4'(DEAD_PERIODS);

  chan_state_t       r_state;
  dir_t              r_dir;
  logic [DUTY_W-1:0] r_eff;
  logic [3:0]        r_dead_cnt;

  dir_t              w_cmd;
  logic [DUTY_W-1:0] w_up;
  logic [DUTY_W-1:0] w_dn;
  logic [DUTY_W-1:0] w_next_eff;

  assign w_cmd = decode_dir(i_a, i_b);

  always_comb begin
    w_up       = i_duty - r_eff;
    w_dn       = r_eff - i_duty;
    w_next_eff = r_eff;
    if (i_duty > r_eff)
      w_next_eff = r_eff + ((w_up < STEP) ? w_up : STEP);
    else if (i_duty < r_eff)
      w_next_eff = r_eff - ((w_dn < STEP) ? w_dn : STEP);
  end

  // State only moves at period boundaries, so duty changes always land on pwm_cnt==0
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_COAST;
      r_dir      <= COAST;
      r_eff      <= '0;
      r_dead_cnt <= '0;
      o_in1      <= 1'b0;
      o_in2      <= 1'b0;
      o_dead     <= 1'b0;
    end else if (!i_enable) begin
      r_state    <= ST_COAST;
      r_dir      <= COAST;
      r_eff      <= '0;
      r_dead_cnt <= '0;
      o_in1      <= 1'b0;
      o_in2      <= 1'b0;
      o_dead     <= 1'b0;
    end else begin
      o_in1  <= (r_state == ST_RUN) && (r_dir == FWD) && (i_pwm_cnt < r_eff);
      o_in2  <= (r_state == ST_RUN) && (r_dir == REV) && (i_pwm_cnt < r_eff);
      o_dead <= (r_state == ST_DEAD);
      if (i_boundary) begin
        case (r_state)
          ST_COAST: begin
            if (w_cmd != COAST) begin
              r_state <= ST_RUN;
              r_dir   <= w_cmd;
              r_eff   <= '0;
            end
          end
          ST_RUN: begin
            if (w_cmd == COAST) begin
              r_state <= ST_COAST;
              r_dir   <= COAST;
              r_eff   <= '0;
            end else if (w_cmd == r_dir) begin
              r_eff <= w_next_eff;
            end else begin
              r_state    <= ST_DEAD;
              r_dir      <= COAST;
              r_eff      <= '0;
              r_dead_cnt <= DEAD_N;
            end
          end
          ST_DEAD: begin
            // Leave on the boundary where the count reaches zero: exactly DEAD_PERIODS periods low
            if (r_dead_cnt <= 4'd1) begin
              r_dead_cnt <= '0;
              r_eff      <= '0;
              if (w_cmd != COAST) begin
                r_state <= ST_RUN;
                r_dir   <= w_cmd;
              end else begin
                r_state <= ST_COAST;
                r_dir   <= COAST;
              end
            end else begin
              r_dead_cnt <= r_dead_cnt - 4'd1;
            end
          end
          default: begin
            r_state <= ST_COAST;
            r_dir   <= COAST;
            r_eff   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - shared PWM timebase and two independent H-bridge channels
import motor_pwm_pkg::*;

module motor_pwm_driver #(
  parameter int PRESCALE     = 4,
  parameter int RAMP_STEP    = 2,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              clk_3125KHz,
  input  logic              reset,
  input  logic              enable,
  input  logic              m1_a,
  input  logic              m1_b,
  input  logic              m2_a,
  input  logic              m2_b,
  input  logic [DUTY_W-1:0] dc1,
  input  logic [DUTY_W-1:0] dc2,
  output logic              l_in1,
  output logic              l_in2,
  output logic              r_in1,
  output logic              r_in2,
  output logic              l_dead,
  output logic              r_dead,
  output logic              period_tick
);

  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

  logic [7:0]        r_presc;
  logic [DUTY_W-1:0] r_pwm_cnt;
  logic              r_period_tick;
  logic              w_presc_wrap;
  logic              w_boundary;

  assign w_presc_wrap = (r_presc == PRESC_MAX);
  assign w_boundary   = w_presc_wrap && (r_pwm_cnt == '1);
  assign period_tick  = r_period_tick;

  // Timebase ignores enable so the period grid stays fixed across coast/run changes
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      r_presc       <= '0;
      r_pwm_cnt     <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_presc       <= w_presc_wrap ? 8'd0 : r_presc + 8'd1;
      r_period_tick <= w_boundary;
      if (w_presc_wrap)
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  motor_pwm_channel #(
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_left (
    .i_clk     (clk_3125KHz),
    .i_reset   (reset),
    .i_enable  (enable),
    .i_boundary(w_boundary),
    .i_pwm_cnt (r_pwm_cnt),
    .i_a       (m1_a),
    .i_b       (m1_b),
    .i_duty    (dc1),
    .o_in1     (l_in1),
    .o_in2     (l_in2),
    .o_dead    (l_dead)
  );

  motor_pwm_channel #(
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_right (
    .i_clk     (clk_3125KHz),
    .i_reset   (reset),
    .i_enable  (enable),
    .i_boundary(w_boundary),
    .i_pwm_cnt (r_pwm_cnt),
    .i_a       (m2_a),
    .i_b       (m2_b),
    .i_duty    (dc2),
    .o_in1     (r_in1),
    .o_in2     (r_in2),
    .o_dead    (r_dead)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - scoreboard bench: per-period high-clock counts of every bridge pin
module tb_motor_pwm_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       m1_a = 1'b0, m1_b = 1'b0, m2_a = 1'b0, m2_b = 1'b0;
  logic [4:0] dc1 = 5'd0, dc2 = 5'd0;
  logic       l_in1, l_in2, r_in1, r_in2, l_dead, r_dead, period_tick;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .PRESCALE    (4),
    .RAMP_STEP   (2),
    .DEAD_PERIODS(2)
  ) dut (
    .clk_3125KHz(clk),
    .reset      (reset),
    .enable     (enable),
    .m1_a       (m1_a),
    .m1_b       (m1_b),
    .m2_a       (m2_a),
    .m2_b       (m2_b),
    .dc1        (dc1),
    .dc2        (dc2),
    .l_in1      (l_in1),
    .l_in2      (l_in2),
    .r_in1      (r_in1),
    .r_in2      (r_in2),
    .l_dead     (l_dead),
    .r_dead     (r_dead),
    .period_tick(period_tick)
  );

  typedef struct {
    bit chk;
    int l1, l2, r1, r2, ld, rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  int   ticks_seen = 0;
  int   pnum = 0;
  int   c_l1 = 0, c_l2 = 0, c_r1 = 0, c_r2 = 0, c_ld = 0, c_rd = 0, c_ov = 0;

  task automatic cmp(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // A window closes on the negedge showing period_tick; it holds the pins of the period that just ended
  always @(negedge clk) begin
    c_l1 += int'(l_in1);
    c_l2 += int'(l_in2);
    c_r1 += int'(r_in1);
    c_r2 += int'(r_in2);
    c_ld += int'(l_dead);
    c_rd += int'(r_dead);
    c_ov += int'((l_in1 && l_in2) || (r_in1 && r_in2));
    if (period_tick) begin
      pnum++;
      cmp($sformatf("p%0d_shoot_through", pnum), c_ov, 0);
      if (armed) begin
        ticks_seen++;
        if (ticks_seen >= 2) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p%0d_scoreboard_empty: got no expectation, expected one", pnum);
          end else begin
            e = sb_q.pop_front();
            if (e.chk) begin
              cmp($sformatf("p%0d_l_in1", pnum), c_l1, e.l1);
              cmp($sformatf("p%0d_l_in2", pnum), c_l2, e.l2);
              cmp($sformatf("p%0d_r_in1", pnum), c_r1, e.r1);
              cmp($sformatf("p%0d_r_in2", pnum), c_r2, e.r2);
              cmp($sformatf("p%0d_l_dead", pnum), c_ld, e.ld);
              cmp($sformatf("p%0d_r_dead", pnum), c_rd, e.rd);
            end
          end
        end
      end
      c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; c_ld = 0; c_rd = 0; c_ov = 0;
    end
  end

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!period_tick && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!period_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no period_tick in %0d clocks, expected one per 128", n);
    end
  endtask

  // Drive commands just after a boundary; expectation is for the period starting at the next boundary
  task automatic step(input bit en, input bit a1, input bit b1, input int d1,
                      input bit a2, input bit b2, input int d2, input bit chk,
                      input int l1, input int l2, input int r1, input int r2,
                      input int ld, input int rd);
    wait_tick();
    #1;
    enable = en;
    m1_a = a1; m1_b = b1; dc1 = 5'(d1);
    m2_a = a2; m2_b = b2; dc2 = 5'(d2);
    sb_q.push_back('{chk, l1, l2, r1, r2, ld, rd});
    armed = 1'b1;
  endtask

  task automatic check_all_low(input string tag);
    cmp({tag, "_l_in1"}, int'(l_in1), 0);
    cmp({tag, "_l_in2"}, int'(l_in2), 0);
    cmp({tag, "_r_in1"}, int'(r_in1), 0);
    cmp({tag, "_r_in2"}, int'(r_in2), 0);
    cmp({tag, "_l_dead"}, int'(l_dead), 0);
    cmp({tag, "_r_dead"}, int'(r_dead), 0);
    cmp({tag, "_period_tick"}, int'(period_tick), 0);
  endtask

  int ramp_fwd16[9] = '{0, 8, 16, 24, 32, 40, 48, 56, 64};
  int ramp_rev20[11] = '{0, 8, 16, 24, 32, 40, 48, 56, 64, 72, 80};

  initial begin
    repeat (3) @(negedge clk);
    check_all_low("reset");
    #1 reset = 1'b0;
    enable = 1'b1;

    // Left FWD to 16 from zero at 2 per period
    foreach (ramp_fwd16[i])
      step(1, 1, 0, 16, 0, 0, 0, 1, ramp_fwd16[i], 0, 0, 0, 0, 0);

    // Left to 20, right starts FWD 10
    step(1, 1, 0, 20, 1, 0, 10, 1, 72, 0, 0, 0, 0, 0);
    step(1, 1, 0, 20, 1, 0, 10, 1, 80, 0, 8, 0, 0, 0);
    // Left reversal: two dead periods, then REV ramp; right keeps ramping
    step(1, 0, 1, 20, 1, 0, 10, 1, 0, 0, 16, 0, 128, 0);
    step(1, 0, 1, 20, 1, 0, 10, 1, 0, 0, 24, 0, 128, 0);
    foreach (ramp_rev20[i])
      step(1, 0, 1, 20, 1, 0, 10, 1, 0, ramp_rev20[i], (i == 0) ? 32 : 40, 0, 0, 0);

    // dc2 10->30 mid-period: current period stays at 40 clocks
    step(1, 0, 1, 20, 1, 0, 30, 1, 0, 80, 48, 0, 0, 0);
    step(1, 0, 1, 20, 1, 0, 30, 1, 0, 80, 56, 0, 0, 0);
    // One-clock REV glitch on the right, away from the boundary
    repeat (20) @(negedge clk);
    #1 m2_a = 1'b0; m2_b = 1'b1;
    @(negedge clk);
    #1 m2_a = 1'b1; m2_b = 1'b0;

    // Illegal 1/1 on the left coasts
    step(1, 1, 1, 20, 1, 0, 30, 1, 0, 0, 64, 0, 0, 0);
    step(1, 1, 1, 20, 1, 0, 30, 1, 0, 0, 72, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 30, 1, 0, 0, 80, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 24, 1, 0, 0, 88, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 24, 1, 0, 0, 96, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 24, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 24, 1, 0, 0, 0, 0, 0, 0);

    // Drop enable mid-period at eff=24
    repeat (10) @(negedge clk);
    cmp("pre_drop_r_in1", int'(r_in1), 1);
    #1 enable = 1'b0;
    @(negedge clk);
    cmp("drop_r_in1", int'(r_in1), 0);
    cmp("drop_r_in2", int'(r_in2), 0);
    cmp("drop_l_in1", int'(l_in1), 0);
    cmp("drop_r_dead", int'(r_dead), 0);

    // Re-enable: right restarts from eff=0; left FWD then reverse into DEAD
    step(1, 0, 0, 0, 1, 0, 24, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 10, 1, 0, 24, 1, 0, 0, 8, 0, 0, 0);
    step(1, 1, 0, 10, 1, 0, 24, 1, 8, 0, 16, 0, 0, 0);
    step(1, 0, 1, 10, 1, 0, 24, 1, 0, 0, 24, 0, 128, 0);
    step(1, 0, 1, 10, 1, 0, 24, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 10, 1, 0, 24, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the second dead period
    repeat (5) @(negedge clk);
    cmp("pre_reset_l_dead", int'(l_dead), 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_low("reset_in_dead");
    #1;
    armed = 1'b0;
    ticks_seen = 0;
    sb_q.delete();
    m1_a = 1'b0; m1_b = 1'b0; m2_a = 1'b0; m2_b = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // FWD after reset goes straight to RUN, no dead interval
    step(1, 1, 0, 10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 10, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    step(1, 1, 0, 10, 0, 0, 0, 1, 16, 0, 0, 0, 0, 0);
    step(1, 1, 0, 10, 0, 0, 0, 1, 24, 0, 0, 0, 0, 0);
    wait_tick();
    wait_tick();
    #1;
    cmp("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
